// File: rtl/data_mem_bytelane_if.sv
// Request/response bundle between the MEM-stage datapath and the byte-lane data memory.
interface data_mem_bytelane_if;
   logic        i_req;
   logic        i_WE;
   logic [1:0]  i_size;
   logic        i_unsigned;
   logic [31:0] i_A;
   logic [31:0] i_WD;
   logic        i_clr;
   logic        o_ready;
   logic        o_rvalid;
   logic [31:0] o_RD;
   logic        o_fault;
   logic [1:0]  o_fault_code;

   modport master (
      output i_req, i_WE, i_size, i_unsigned, i_A, i_WD, i_clr,
      input  o_ready, o_rvalid, o_RD, o_fault, o_fault_code
   );

   modport slave (
      input  i_req, i_WE, i_size, i_unsigned, i_A, i_WD, i_clr,
      output o_ready, o_rvalid, o_RD, o_fault, o_fault_code
   );
endinterface

// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory: LB/LBU/LH/LHU/LW and SB/SH/SW with fault reporting
// and a hardware clear sweep. Loads return registered, extended data one cycle later.
module data_mem_bytelane #(
   parameter int unsigned ADDR_W         = 12,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   data_mem_bytelane_if.slave   bus
);
   localparam int unsigned      WORDS    = 2 ** (ADDR_W - 2);
   localparam int unsigned      CNT_W    = ADDR_W - 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_ALIGN = 2'b01;
   localparam logic [1:0] FC_RANGE = 2'b10;
   localparam logic [1:0] FC_SIZE  = 2'b11;

   typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             rvalid_q, rvalid_d;
   logic             fault_q, fault_d;
   logic [1:0]       code_q, code_d;
   logic [31:0]      rd_q, rd_d;

   logic [31:0]      mem [WORDS];

   logic [CNT_W-1:0] idx_c, widx_c;
   logic [1:0]       lane_c, fcode_c;
   logic             accept_c;
   logic [3:0]       we_c;
   logic [31:0]      wdata_c, rword_c, shifted_c, load_c;

   assign idx_c     = bus.i_A[ADDR_W-1:2];
   assign lane_c    = bus.i_A[1:0];
   assign accept_c  = ready_q && (state_q == S_IDLE) && bus.i_req && !bus.i_clr;
   assign rword_c   = mem[idx_c];
   assign shifted_c = rword_c >> {lane_c, 3'b000};

   // Fault classification, highest priority first
   always_comb begin
      fcode_c = FC_NONE;
      if (bus.i_size == FC_SIZE)
         fcode_c = FC_SIZE;
      else if ((bus.i_size == SZ_HALF && bus.i_A[0]) ||
               (bus.i_size == SZ_WORD && lane_c != 2'b00))
         fcode_c = FC_ALIGN;
      else if ((bus.i_A >> ADDR_W) != 32'd0)
         fcode_c = FC_RANGE;
   end

   always_comb begin
      load_c = shifted_c;
      case (bus.i_size)
         SZ_BYTE: load_c = bus.i_unsigned ? {24'd0, shifted_c[7:0]}
                                          : {{24{shifted_c[7]}}, shifted_c[7:0]};
         SZ_HALF: load_c = bus.i_unsigned ? {16'd0, shifted_c[15:0]}
                                          : {{16{shifted_c[15]}}, shifted_c[15:0]};
         default: load_c = shifted_c;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: if (cnt_q == CNT_LAST) state_d = S_IDLE;
         S_IDLE:  if (ready_q && bus.i_clr) state_d = S_CLEAR;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath control
   always_comb begin
      ready_d  = (state_d == S_IDLE);
      cnt_d    = cnt_q;
      rvalid_d = 1'b0;
      fault_d  = 1'b0;
      code_d   = FC_NONE;
      rd_d     = rd_q;
      we_c     = 4'b0000;
      wdata_c  = 32'd0;
      widx_c   = idx_c;
      if (state_q == S_CLEAR) begin
         we_c   = 4'b1111;
         widx_c = cnt_q;
         if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_q == S_IDLE && ready_q && bus.i_clr) cnt_d = '0;
      if (accept_c) begin
         if (fcode_c != FC_NONE) begin
            fault_d = 1'b1;
            code_d  = fcode_c;
            if (!bus.i_WE) begin
               rvalid_d = 1'b1;
               rd_d     = 32'd0;
            end
         end else if (bus.i_WE) begin
            case (bus.i_size)
               SZ_BYTE: begin
                  we_c    = 4'b0001 << lane_c;
                  wdata_c = {4{bus.i_WD[7:0]}};
               end
               SZ_HALF: begin
                  we_c    = 4'b0011 << lane_c;
                  wdata_c = {2{bus.i_WD[15:0]}};
               end
               default: begin
                  we_c    = 4'b1111;
                  wdata_c = bus.i_WD;
               end
            endcase
         end else begin
            rvalid_d = 1'b1;
            rd_d     = load_c;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         rvalid_q <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= FC_NONE;
         rd_q     <= 32'd0;
      end else begin
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
         rd_q     <= rd_d;
      end
   end

   // Storage is deliberately left out of reset; the clear sweep initialises it
   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++)
         if (we_c[b]) mem[widx_c][8*b +: 8] <= wdata_c[8*b +: 8];
   end

   assign bus.o_ready      = ready_q;
   assign bus.o_rvalid     = rvalid_q;
   assign bus.o_RD         = rd_q;
   assign bus.o_fault      = fault_q;
   assign bus.o_fault_code = code_q;
endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed + randomized check of data_mem_bytelane (ADDR_W=6) against a byte-array model.
module tb_data_mem_bytelane;
   localparam int unsigned NBYTES = 64;

   logic clk;
   logic rst_n;
   data_mem_bytelane_if bus ();

   data_mem_bytelane #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [7:0]  mem_m [NBYTES];
   logic [31:0] last_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_code(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 2'd3;
      if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) return 2'd1;
      if (a >= 32'(NBYTES)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                            input logic [31:0] a);
      int n = 1 << sz;
      logic [31:0] v = 32'd0;
      for (int i = 0; i < n; i++) begin
         logic [5:0] ix = a[5:0] + 6'(i);
         v = v | (32'(mem_m[ix]) << (8 * i));
      end
      if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < int'(NBYTES); i++) mem_m[i] = 8'h00;
   endtask

   // One access, accepted on the next rising edge; results checked at the following negedge
   task automatic acc(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input string tag);
      logic [1:0]  c;
      logic [31:0] e;
      chk({tag, ".ready"}, 32'(bus.o_ready), 32'd1);
      c = exp_code(sz, a);
      e = 32'd0;
      if (c == 2'd0 && !we) e = exp_load(sz, uns, a);
      bus.i_req = 1'b1; bus.i_WE = we; bus.i_size = sz; bus.i_unsigned = uns;
      bus.i_A = a; bus.i_WD = wd;
      @(negedge clk);
      bus.i_req = 1'b0; bus.i_WE = 1'b0;
      if (c == 2'd0 && we)
         for (int i = 0; i < (1 << sz); i++) begin
            logic [5:0] ix = a[5:0] + 6'(i);
            mem_m[ix] = wd[8*i +: 8];
         end
      if (!we) last_rd = e;
      chk({tag, ".fault"},  32'(bus.o_fault),      32'(c != 2'd0));
      chk({tag, ".code"},   32'(bus.o_fault_code), 32'(c));
      chk({tag, ".rvalid"}, 32'(bus.o_rvalid),     32'(!we));
      chk({tag, ".rd"},     bus.o_RD,              last_rd);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!bus.o_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk({tag, ".busy_cycles"}, 32'(n), 32'd16);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".ready"},  32'(bus.o_ready),      32'd0);
      chk({tag, ".rvalid"}, 32'(bus.o_rvalid),     32'd0);
      chk({tag, ".fault"},  32'(bus.o_fault),      32'd0);
      chk({tag, ".code"},   32'(bus.o_fault_code), 32'd0);
      chk({tag, ".rd"},     bus.o_RD,              32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.i_req = 1'b0; bus.i_WE = 1'b0; bus.i_size = 2'd0; bus.i_unsigned = 1'b0;
      bus.i_A = 32'd0; bus.i_WD = 32'd0; bus.i_clr = 1'b0;
      last_rd = 32'd0;
      model_clear();
      #1;
      chk_reset_outputs("por");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      wait_ready("por_sweep");
      acc(1'b0, 2'd2, 1'b0, 32'h3C, 32'd0, "lw_3c_cleared");

      acc(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, "sw_10");
      acc(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, "lb_10");
      chk("lb_10.const", bus.o_RD, 32'hFFFFFFBB);
      acc(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, "lbu_13");
      chk("lbu_13.const", bus.o_RD, 32'h00000088);
      acc(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, "lh_12");
      chk("lh_12.const", bus.o_RD, 32'hFFFF8899);
      acc(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, "lhu_10");
      chk("lhu_10.const", bus.o_RD, 32'h0000AABB);
      acc(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "lw_10");
      acc(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000011, "sb_11");
      acc(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "lw_10_after_sb");
      chk("lw_10_after_sb.const", bus.o_RD, 32'h889911BB);

      acc(1'b0, 2'd2, 1'b0, 32'h12, 32'd0, "lw_misaligned");
      acc(1'b1, 2'd1, 1'b0, 32'h01, 32'h0000BEEF, "sh_misaligned");
      acc(1'b0, 2'd2, 1'b0, 32'h00, 32'd0, "lw_00_unchanged");
      acc(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, "lw_out_of_range");
      acc(1'b1, 2'd2, 1'b0, 32'h80000000, 32'h12345678, "sw_out_of_range");
      acc(1'b0, 2'd3, 1'b0, 32'h04, 32'd0, "ld_bad_size");
      acc(1'b1, 2'd3, 1'b0, 32'h06, 32'hCAFEF00D, "st_bad_size");

      // Randomized back-to-back traffic
      for (int k = 0; k < 300; k++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63));
         if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         acc(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, 32'($urandom), "rand");
      end

      // Clear and store requested together: clear wins
      acc(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, "sw_20_pre_clr");
      bus.i_clr = 1'b1; bus.i_req = 1'b1; bus.i_WE = 1'b1; bus.i_size = 2'd2;
      bus.i_A = 32'h24; bus.i_WD = 32'h5A5A5A5A;
      @(negedge clk);
      bus.i_clr = 1'b0; bus.i_req = 1'b0; bus.i_WE = 1'b0;
      chk("clr_req.fault",  32'(bus.o_fault),  32'd0);
      chk("clr_req.rvalid", 32'(bus.o_rvalid), 32'd0);
      wait_ready("clr_sweep");
      model_clear();
      for (int w = 0; w < 16; w++) acc(1'b0, 2'd2, 1'b0, 32'(4 * w), 32'd0, "lw_after_clr");

      // Reset in the middle of a sweep
      acc(1'b1, 2'd2, 1'b0, 32'h08, 32'h0BADF00D, "sw_08_pre_rst");
      acc(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, "lw_08_pre_rst");
      bus.i_clr = 1'b1;
      @(negedge clk);
      bus.i_clr = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_clr.ready", 32'(bus.o_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_clr_rst");
      last_rd = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("restart_sweep");
      model_clear();
      acc(1'b0, 2'd2, 1'b0, 32'h3C, 32'd0, "lw_3c_after_restart");
      acc(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, "lw_08_after_restart");

      // Reset while a load response is in flight
      acc(1'b1, 2'd2, 1'b0, 32'h30, 32'h13572468, "sw_30");
      bus.i_req = 1'b1; bus.i_WE = 1'b0; bus.i_size = 2'd2; bus.i_A = 32'h30;
      @(posedge clk);
      #1;
      bus.i_req = 1'b0;
      chk("inflight.rvalid_pre", 32'(bus.o_rvalid), 32'd1);
      chk("inflight.rd_pre", bus.o_RD, 32'h13572468);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("inflight_rst");
      last_rd = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("inflight.no_pulse", 32'(bus.o_rvalid), 32'd0);
      wait_ready("inflight_sweep");
      model_clear();
      acc(1'b0, 2'd0, 1'b1, 32'h31, 32'd0, "lbu_31_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/data_mem_bytelane.md
Name: data_mem_bytelane

Overview:
- Parametrised successor to the single-cycle word data memory for the MIPS core.
- Adds byte/halfword/word access with byte-lane write enables, and sign/zero-extended loads (LB/LBU/LH/LHU/LW, SB/SH/SW).
- Adds alignment and range fault reporting, plus a hardware memory-clear sequencer that replaces the per-element reset loop.
- Sits between the MEM-stage address/data path and the writeback mux. Reads are registered with a 1-cycle valid handshake.

Parameters:
ADDR_W, 12, byte-address bits decoded; storage = 2**ADDR_W bytes (2**(ADDR_W-2) 32-bit words)
CLEAR_ON_RESET, 1, 1 = run the clear sweep automatically after reset release; 0 = come up ready, contents undefined

Ports:
i_clk  input  1  core clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset (control state only; storage array not reset)
i_req  input  1  access request, sampled when o_ready=1
i_WE  input  1  1 = store, 0 = load
i_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as fault)
i_unsigned  input  1  load zero-extends when 1, sign-extends when 0
i_A  input  32  byte address
i_WD  input  32  store data, right-justified (byte in [7:0], half in [15:0])
i_clr  input  1  request full clear sweep, sampled when o_ready=1
o_ready  output  1  block can accept i_req / i_clr this cycle
o_rvalid  output  1  one-cycle pulse: o_RD valid for the load accepted previous cycle
o_RD  output  32  extended load data
o_fault  output  1  one-cycle pulse: access accepted previous cycle faulted
o_fault_code  output  2  01 misaligned, 10 out of range, 11 bad size; 00 when no fault

Behaviour:
- Storage: 2**(ADDR_W-2) words × 32 bits with 4 byte-write enables. Word index = i_A[ADDR_W-1:2]; lane = i_A[1:0]; little-endian (lane 0 = bits [7:0]).
- Reset (async, i_rst_n=0): o_ready=0, o_rvalid=0, o_fault=0, o_fault_code=00, o_RD=0, clear counter=0. FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
- FSM states:
  - CLEAR: writes 0 to word[cnt], cnt += 1 per cycle, o_ready=0. Leaves after the last word is written (exactly 2**(ADDR_W-2) cycles), entering IDLE with o_ready=1 on the next cycle.
  - IDLE: o_ready=1. i_clr=1 → CLEAR (cnt=0); i_req is ignored that cycle (i_clr has priority). i_req=1 → ACCESS actions below on the same edge; FSM stays IDLE, enabling back-to-back accesses.
- Acceptance = i_req & o_ready & ~i_clr. Checks are evaluated combinationally on the accepted cycle.
- Fault checks, in priority order:
  - bad size (i_size=11) → code 11
  - misaligned (half with A[0]=1; word with A[1:0]≠00) → code 01
  - out of range (A[31:ADDR_W]≠0) → code 10
- Faulted access: no storage write. Next cycle o_fault=1 with the code; o_rvalid=1 only if it was a load, with o_RD=0.
- Store: byte enables: byte = 1<<A[1:0]; half = 0011<<A[1:0]; word = 1111. i_WD replicated to the addressed lanes. Committed on the acceptance edge. o_rvalid stays 0.
- Load: word read on the acceptance edge. Next cycle o_rvalid=1 and o_RD = selected lane(s) shifted to bit 0, extended per i_unsigned (word ignores i_unsigned).
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data. Same-cycle load+store is impossible (single port).
- o_RD holds its last value when o_rvalid=0.
- Reset asserted mid-CLEAR: sweep aborts. After release it restarts from word 0 (CLEAR_ON_RESET=1) or goes to IDLE with partially cleared contents (CLEAR_ON_RESET=0).
- Reset asserted with a load in flight: o_rvalid is suppressed; no pulse after release.
- Counter width ADDR_W-2; terminal value 2**(ADDR_W-2)-1; no wrap beyond it.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, ADDR_W=6 → o_ready low exactly 16 cycles then high. LW of 0x3C → o_rvalid next cycle, o_RD=0x00000000.
- SW 0x8899AABB @0x10; then LB @0x10 → 0xFFFFFFBB; LBU @0x13 → 0x00000088; LH @0x12 → 0xFFFF8899; LHU @0x10 → 0x0000AABB; LW @0x10 → 0x8899AABB.
- SB 0x11 @0x11 after the SW above → LW @0x10 = 0x889911BB. Back-to-back store then load on consecutive cycles returns the new data.
- Misaligned and out-of-range: LW @0x12 → o_fault=1, code 01, o_RD=0. SH @0x01 → code 01, memory unchanged. LW @0x40 (ADDR_W=6) → code 10. i_size=11 → code 11.
- i_clr and i_req asserted together after a nonzero store → store ignored, o_ready low 16 cycles, subsequent LW of every word returns 0.
- i_rst_n pulsed low at cycle 5 of a CLEAR sweep → outputs zero asynchronously; after release the sweep restarts (16 full cycles of o_ready=0).
